// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared types and constants for the ALU operand stage
// Holds the B-operand source select encoding and the call-constant helper.
package alu_operand_stage_pkg;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_CALL = 2'd2,
    SRC_FWD  = 2'd3
  } src_sel_t;

  localparam int unsigned CALL_MAX_W = 256;

  // The caller keeps the low w bits.
  function automatic logic [CALL_MAX_W-1:0] call_const(input int unsigned w);
    return {CALL_MAX_W{1'b1}} >> (CALL_MAX_W - w);
  endfunction

endpackage

// File: rtl/alu_operand_stage_skid.sv
// rtl/alu_operand_stage_skid.sv - 2-entry valid/ready skid buffer for the operand stage
// The main register drives the outputs; the skid entry absorbs one operand while stalled.
module alu_operand_stage_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             full_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_valid_i) begin
          main_d  = in_data_i;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_valid_i && out_ready_i) begin
          main_d = in_data_i;
        end else if (in_valid_i) begin
          skid_d  = in_data_i;
          state_d = S_FULL;
        end else if (out_ready_i) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_valid_i is never asserted here; the parent gates accept with full_o.
        if (out_ready_i) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign full_o      = (state_q == S_FULL);
  assign out_valid_o = (state_q != S_EMPTY);
  assign out_data_o  = main_q;

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - B-operand select, forwarding stall and skid output stage
// Forwarding selection, stall detection and the stall counter exist only with ALU_OPERAND_FWD_EN.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_FWD   = 2,
  parameter int FWD_IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1,
  parameter int CNT_W     = 16
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [1:0]               iSrcSel,
  input  logic [FWD_IDX_W-1:0]     iFwdIdx,
  input  logic [WIDTH-1:0]         iSrc,
  input  logic [WIDTH-1:0]         iImmediate,
  input  logic [NUM_FWD*WIDTH-1:0] iFwdData,
  input  logic [NUM_FWD-1:0]       iFwdValid,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [WIDTH-1:0]         oSrc,
  output logic [CNT_W-1:0]         oStallCnt
);

  localparam logic [CALL_MAX_W-1:0] CALL_FULL = call_const(WIDTH);
  localparam logic [WIDTH-1:0]      CALL_VAL  = CALL_FULL[WIDTH-1:0];

  src_sel_t         sel;
  logic [WIDTH-1:0] operand;
  logic             fwd_stall;
  logic             full;
  logic             accept;

  assign sel = src_sel_t'(iSrcSel);

`ifdef ALU_OPERAND_FWD_EN
  logic [WIDTH-1:0] fwd_data;
  logic             fwd_ok;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // An index with no matching source leaves fwd_ok low, so it stalls forever.
  always_comb begin
    fwd_data = '0;
    fwd_ok   = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (iFwdIdx == FWD_IDX_W'(k)) begin
        fwd_data = iFwdData[k*WIDTH +: WIDTH];
        fwd_ok   = iFwdValid[k];
      end
    end
  end

  assign fwd_stall = iValid && (sel == SRC_FWD) && !fwd_ok;

  always_comb begin
    operand = iSrc;
    case (sel)
      SRC_REG:  operand = iSrc;
      SRC_IMM:  operand = iImmediate;
      SRC_CALL: operand = CALL_VAL;
      SRC_FWD:  operand = fwd_data;
      default:  operand = iSrc;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (fwd_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oStallCnt = stall_cnt_q;
`else
  logic unused_fwd;

  assign unused_fwd = ^{iFwdData, iFwdValid, iFwdIdx};
  assign fwd_stall  = 1'b0;

  always_comb begin
    operand = iSrc;
    case (sel)
      SRC_REG:  operand = iSrc;
      SRC_IMM:  operand = iImmediate;
      SRC_CALL: operand = CALL_VAL;
      SRC_FWD:  operand = iSrc;
      default:  operand = iSrc;
    endcase
  end

  assign oStallCnt = '0;
`endif

  assign accept = iValid && !fwd_stall && !full;
  assign oReady = !full && !fwd_stall;

  alu_operand_stage_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i       (iClk),
    .rst_ni      (iRstN),
    .in_valid_i  (accept),
    .in_data_i   (operand),
    .full_o      (full),
    .out_valid_o (oValid),
    .out_data_o  (oSrc),
    .out_ready_i (iReady)
  );

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
// Expectations follow ALU_OPERAND_FWD_EN as compiled.
module tb_alu_operand_stage;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iValid, iReady;
  logic [1:0]  iSrcSel;
  logic [0:0]  iFwdIdx;
  logic [31:0] iSrc, iImmediate;
  logic [63:0] iFwdData;
  logic [1:0]  iFwdValid;
  logic        oReady, oValid;
  logic [31:0] oSrc;
  logic [15:0] oStallCnt;

  logic        rst_aux;
  logic        r16, v16;
  logic [15:0] src16;
  logic [15:0] cnt16;
  logic        rc4, vc4;
  logic [31:0] srcc4;
  logic [3:0]  cntc4;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  alu_operand_stage #(.WIDTH(32), .NUM_FWD(2), .CNT_W(16)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iSrcSel(iSrcSel), .iFwdIdx(iFwdIdx), .iSrc(iSrc), .iImmediate(iImmediate),
    .iFwdData(iFwdData), .iFwdValid(iFwdValid), .oValid(oValid), .iReady(iReady),
    .oSrc(oSrc), .oStallCnt(oStallCnt)
  );

  alu_operand_stage #(.WIDTH(16), .NUM_FWD(2), .CNT_W(16)) dut16 (
    .iClk(iClk), .iRstN(rst_aux), .iValid(1'b1), .oReady(r16),
    .iSrcSel(2'd2), .iFwdIdx(1'b0), .iSrc(16'h1111), .iImmediate(16'h2222),
    .iFwdData(32'h0), .iFwdValid(2'b00), .oValid(v16), .iReady(1'b1),
    .oSrc(src16), .oStallCnt(cnt16)
  );

  alu_operand_stage #(.WIDTH(32), .NUM_FWD(2), .CNT_W(4)) dut_c4 (
    .iClk(iClk), .iRstN(rst_aux), .iValid(1'b1), .oReady(rc4),
    .iSrcSel(2'd3), .iFwdIdx(1'b0), .iSrc(32'h5), .iImmediate(32'h6),
    .iFwdData(64'h0), .iFwdValid(2'b00), .oValid(vc4), .iReady(1'b1),
    .oSrc(srcc4), .oStallCnt(cntc4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  initial begin
    iRstN = 1'b0; rst_aux = 1'b0;
    iValid = 1'b0; iReady = 1'b1; iSrcSel = 2'd0; iFwdIdx = 1'b0;
    iSrc = 32'h0; iImmediate = 32'h0; iFwdData = 64'h0; iFwdValid = 2'b00;
    #1;
    check("rst_valid", oValid, 0);
    check("rst_src", oSrc, 0);
    check("rst_cnt", oStallCnt, 0);
    check("rst_ready", oReady, 1);
    tick();
    iRstN = 1'b1; rst_aux = 1'b1;

    iValid = 1'b1; iSrcSel = 2'd1; iImmediate = 32'h0000_0ABC;
    tick();
    iValid = 1'b0;
    check("imm_valid", oValid, 1);
    check("imm_src", oSrc, 32'h0000_0ABC);
    tick();
    check("imm_drain", oValid, 0);

    iValid = 1'b1; iSrcSel = 2'd2;
    tick();
    iValid = 1'b0;
    check("call32_src", oSrc, 32'hFFFF_FFFF);
    check("call16_src", src16, 16'hFFFF);
    check("call16_valid", v16, 1);
    tick();

    iValid = 1'b1; iSrcSel = 2'd3; iFwdIdx = 1'b1; iFwdValid = 2'b01;
    iFwdData = {32'h0000_1234, 32'h0000_DEAD}; iSrc = 32'h0000_5555;
`ifdef ALU_OPERAND_FWD_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fwd_stall_ready", oReady, 0);
      tick();
    end
    check("fwd_stall_novalid", oValid, 0);
    iFwdValid = 2'b11;
    #1;
    check("fwd_go_ready", oReady, 1);
    tick();
    iValid = 1'b0;
    check("fwd_src", oSrc, 32'h0000_1234);
    check("fwd_cnt", oStallCnt, 3);
`else
    #1;
    check("fwd_off_ready", oReady, 1);
    tick();
    iValid = 1'b0;
    check("fwd_off_src", oSrc, 32'h0000_5555);
    check("fwd_off_cnt", oStallCnt, 0);
`endif
    check("fwd_valid", oValid, 1);
    tick();

    iReady = 1'b0; iValid = 1'b1; iSrcSel = 2'd0; iSrc = 32'd1;
    #1;
    check("b2b_ready0", oReady, 1);
    tick();
    iSrc = 32'd2;
    tick();
    iSrc = 32'd3;
    #1;
    check("b2b_full_ready", oReady, 0);
    check("b2b_hold1", oSrc, 32'd1);
    tick();
    check("b2b_stable_src", oSrc, 32'd1);
    check("b2b_stable_valid", oValid, 1);
    iReady = 1'b1;
    tick();
    check("b2b_out2", oSrc, 32'd2);
    tick();
    check("b2b_out3", oSrc, 32'd3);
    check("b2b_out3_valid", oValid, 1);
    iValid = 1'b0;
    tick();
    check("b2b_empty", oValid, 0);

    iReady = 1'b0; iValid = 1'b1; iSrc = 32'd7;
    tick();
    iSrc = 32'd8;
    tick();
    #1;
    check("full_before_rst", oReady, 0);
    iSrc = 32'd9;
    iRstN = 1'b0;
    #1;
    check("arst_valid", oValid, 0);
    check("arst_src", oSrc, 0);
    check("arst_cnt", oStallCnt, 0);
    check("arst_ready", oReady, 1);
    #1;
    iRstN = 1'b1; iReady = 1'b1;
    tick();
    iValid = 1'b0;
    check("post_rst_src", oSrc, 32'd9);
    check("post_rst_valid", oValid, 1);
    tick();
    check("post_rst_alone", oValid, 0);

`ifdef ALU_OPERAND_FWD_EN
    check("sat_cnt", cntc4, 4'd15);
    check("sat_ready", rc4, 0);
`else
    check("sat_off_cnt", cntc4, 4'd0);
    check("sat_off_src", srcc4, 32'h5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered, parametrised operand-select stage placed between register-file read and ALU execute. Each accepted operation has its B-operand chosen from:
- register data;
- sign-extended immediate;
- the all-ones call constant;
- one of NUM_FWD forwarding buses.

The chosen value is delivered through a 2-entry valid/ready skid buffer. The block stalls operations whose selected forwarding source is not yet valid, and counts those stall cycles.

## Interface
- WIDTH, 32, operand width in bits (≥ 8)
- NUM_FWD, 2, forwarding sources (1..8)
- FWD_IDX_W, $clog2(NUM_FWD) min 1, forwarding index width
- CNT_W, 16, stall counter width
- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous active-low reset
- iValid  in  1  upstream operation valid
- oReady  out  1  stage can accept
- iSrcSel  in  2  SRC_REG=0, SRC_IMM=1, SRC_CALL=2, SRC_FWD=3
- iFwdIdx  in  FWD_IDX_W  forwarding source index
- iSrc  in  WIDTH  register-file operand
- iImmediate  in  WIDTH  sign-extended immediate
- iFwdData  in  NUM_FWD*WIDTH  forwarding data, source k at [k*WIDTH +: WIDTH]
- iFwdValid  in  NUM_FWD  forwarding data valid per source
- oValid  out  1  operand valid downstream
- iReady  in  1  downstream accepts
- oSrc  out  WIDTH  selected operand
- oStallCnt  out  CNT_W  saturating count of forwarding-stall cycles

## Operation
- Operand selection:
  - SRC_REG → iSrc
  - SRC_IMM → iImmediate
  - SRC_CALL → {WIDTH{1'b1}}
  - SRC_FWD → iFwdData[iFwdIdx]
- Forwarding stall (fwdStall) = iValid & iSrcSel==SRC_FWD & ~iFwdValid[iFwdIdx].
- iFwdIdx ≥ NUM_FWD is treated as always stalled.
- Accept = iValid & ~fwdStall & ~full. This is the only combinational valid-to-ready path.
- oReady = ~full & ~fwdStall.
- Skid buffer: main register (drives oSrc/oValid) plus one skid entry; full = skid entry occupied.
  - Data is never dropped or duplicated.
  - Order is preserved.
- Buffer transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with iReady, or with no accept and no iReady.
  - ONE → EMPTY on no accept with iReady.
  - ONE → FULL on accept without iReady.
  - FULL → ONE on iReady; the skid entry moves to main.
  - No accept is possible while FULL.
- oStallCnt increments by 1 on each cycle fwdStall is true, whether or not the buffer is full. It saturates at all-ones and never wraps.

## Timing
- Latency: accepted at edge N → oValid=1 with the selected value after edge N.
- Throughput: one operation per cycle while iReady=1.
- Once asserted, oValid/oSrc stay stable until iValid... until (oValid & iReady) is sampled.
- Simultaneous accept and drain in state ONE: new operand replaces main in the same edge.
- Reset (async assert, any state): oValid=0, oSrc=0, oStallCnt=0, skid entry emptied, oReady=1 unless fwdStall. Any in-flight operands are discarded.

## Configuration
- ALU_OPERAND_FWD_EN defined: forwarding selection, stall logic and oStallCnt behave as above.
- Undefined:
  - SRC_FWD behaves as SRC_REG.
  - iFwdData, iFwdValid and iFwdIdx are ignored.
  - fwdStall is constant 0.
  - oStallCnt is tied to 0.
  - Ports remain present.

## Structure
- ProcessorPkg holds:
  - the src_sel_t enum (SRC_REG/IMM/CALL/FWD);
  - the CALL_CONST function returning all-ones for a given width.
- Sub-module SkidBuffer (parameter WIDTH) holds the main and skid registers and the EMPTY/ONE/FULL handshake.
- AluOperandStage owns selection, stall detection and the counter.

## Test plan
- Reset, then iSrcSel=SRC_IMM, iImmediate=0x0000_0ABC, iReady=1 → next cycle oValid=1, oSrc=0x0000_0ABC.
- SRC_CALL with WIDTH=32 → oSrc=0xFFFF_FFFF. Repeat at WIDTH=16 → oSrc=0xFFFF.
- SRC_FWD, iFwdIdx=1, iFwdValid=2'b01 for 3 cycles, then 2'b11 with data 0x1234 → oReady low for 3 cycles, oStallCnt=3, then oSrc=0x1234.
- Back-to-back values 1, 2, 3 with iReady=0 → after 2 accepts oReady=0. Raise iReady → outputs 1, 2, 3 in order, none lost.
- CNT_W=4, hold the stall for 20 cycles → oStallCnt stops at 15.
- Assert iRstN=0 while FULL → oValid=0, oSrc=0, oStallCnt=0 immediately. After release, the first accepted value appears alone.
